// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory
// request outstanding, and loads the IF/ID pipeline register. A one-entry
// skid buffer catches a response that arrives while the hazard unit stalls.
//
// Optional build macro: IF_FETCH_PERF_EN
//   When defined, adds output if_fetch_count, a wrapping count of valid
//   instructions loaded into IF/ID.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_out,
    output logic        if_id_ins_valid
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] if_fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_nxt;
    logic        r_kill;
    logic        w_kill_nxt;
    logic [31:0] r_skid_data;
    logic [31:0] w_skid_data_nxt;
    logic [31:0] r_skid_pc;
    logic [31:0] w_skid_pc_nxt;

    logic        w_req_hs;
    logic        w_deliver;
    logic [31:0] w_deliver_data;
    logic [31:0] w_deliver_pc;
    logic        w_load_if_id;

    logic [31:0] r_if_id_instruction;
    logic [31:0] r_if_id_pc_out;
    logic        r_if_id_ins_valid;

    assign w_req_hs     = (r_state == S_REQ) && imem_req_ready;
    // A delivery only reaches IF/ID when neither flush nor stall wins.
    assign w_load_if_id = w_deliver && !redirect_valid && !stall;

    assign if_id_instruction = r_if_id_instruction;
    assign if_id_pc_out      = r_if_id_pc_out;
    assign if_id_ins_valid   = r_if_id_ins_valid;

    // Request interface decodes straight from state and PC.
    always_comb begin
        imem_req_valid = (r_state == S_REQ);
        imem_addr      = r_pc;
    end

    // Next-state and datapath decode for the fetch controller.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_kill_nxt      = r_kill;
        w_skid_data_nxt = r_skid_data;
        w_skid_pc_nxt   = r_skid_pc;
        w_deliver       = 1'b0;
        w_deliver_data  = imem_rsp_data;
        w_deliver_pc    = r_fetch_pc;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (w_req_hs) begin
                    w_fetch_pc_nxt = r_pc;
                    w_state_nxt    = S_WAIT;
                    if (redirect_valid) begin
                        // Request already accepted: its response must be dropped.
                        w_pc_nxt   = redirect_pc;
                        w_kill_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end else if (redirect_valid) begin
                    // Not yet accepted, so the address can simply change.
                    w_pc_nxt = redirect_pc;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (r_kill || redirect_valid) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                        if (redirect_valid) begin
                            w_pc_nxt = redirect_pc;
                        end else begin
                            w_pc_nxt = r_pc;
                        end
                    end else if (!stall) begin
                        w_deliver      = 1'b1;
                        w_deliver_data = imem_rsp_data;
                        w_deliver_pc   = r_fetch_pc;
                        w_state_nxt    = S_REQ;
                    end else begin
                        w_skid_data_nxt = imem_rsp_data;
                        w_skid_pc_nxt   = r_fetch_pc;
                        w_state_nxt     = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_kill_nxt = 1'b1;
                    w_pc_nxt   = redirect_pc;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = S_REQ;
                end else if (!stall) begin
                    w_deliver      = 1'b1;
                    w_deliver_data = r_skid_data;
                    w_deliver_pc   = r_skid_pc;
                    w_state_nxt    = S_REQ;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Fetch controller state, PC, kill flag and skid buffer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_fetch_pc  <= 32'h0000_0000;
            r_kill      <= 1'b0;
            r_skid_data <= 32'h0000_0000;
            r_skid_pc   <= 32'h0000_0000;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_kill      <= w_kill_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_pc   <= w_skid_pc_nxt;
        end
    end

    // IF/ID register: reset, then flush, then stall-hold, then load, else bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_if_id_instruction <= BUBBLE_INSN;
            r_if_id_pc_out      <= 32'h0000_0000;
            r_if_id_ins_valid   <= 1'b0;
        end else if (redirect_valid) begin
            r_if_id_instruction <= BUBBLE_INSN;
            r_if_id_pc_out      <= r_if_id_pc_out;
            r_if_id_ins_valid   <= 1'b0;
        end else if (stall) begin
            r_if_id_instruction <= r_if_id_instruction;
            r_if_id_pc_out      <= r_if_id_pc_out;
            r_if_id_ins_valid   <= r_if_id_ins_valid;
        end else if (w_deliver) begin
            r_if_id_instruction <= w_deliver_data;
            r_if_id_pc_out      <= w_deliver_pc;
            r_if_id_ins_valid   <= 1'b1;
        end else begin
            r_if_id_instruction <= BUBBLE_INSN;
            r_if_id_pc_out      <= r_if_id_pc_out;
            r_if_id_ins_valid   <= 1'b0;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] r_fetch_count;

    assign if_fetch_count = r_fetch_count;

    // Count valid instructions loaded into IF/ID; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_count <= 32'h0000_0000;
        end else if (w_load_if_id) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end else begin
            r_fetch_count <= r_fetch_count;
        end
    end
`else
    // Without the counter the load strobe has no consumer.
    logic w_unused_load;
    assign w_unused_load = w_load_if_id;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed scenarios followed by randomized stall/redirect/ready/latency
// traffic. The reference model is transaction level: instructions must
// reach IF/ID in program order (sequential PCs, restarting at the latest
// redirect target), carrying the memory word of their PC, with flush and
// stall-hold behaviour checked every cycle.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_INSN = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_out;
    logic        if_id_ins_valid;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] if_fetch_count;
`endif

    if_fetch_stage #(
        .RESET_PC    (RESET_PC),
        .BUBBLE_INSN (BUBBLE_INSN)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_addr         (imem_addr),
        .imem_rsp_valid    (imem_rsp_valid),
        .imem_rsp_data     (imem_rsp_data),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_out      (if_id_pc_out),
        .if_id_ins_valid   (if_id_ins_valid)
`ifdef IF_FETCH_PERF_EN
        ,
        .if_fetch_count    (if_fetch_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          deliveries = 0;
    int          hs_count   = 0;
    int          cfg_lat    = 1;
    logic        pend       = 1'b0;
    logic [31:0] pend_addr  = 32'h0;
    int          wait_cnt   = 0;
    logic        stale_inject = 1'b0;
    logic [31:0] exp_next   = RESET_PC;
    logic [31:0] perf_model = 32'h0;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0050_0093;
        else if (a == 32'h0000_0004) return 32'h0010_0113;
        else return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One clock: drive memory response, advance, then check against the model.
    task automatic cycle();
        logic        hs;
        logic        rsp_now;
        logic [31:0] hs_addr;
        logic [31:0] p_ins;
        logic [31:0] p_pc;
        logic        p_valid;
        logic        p_stall;
        logic        p_redir;
        logic        p_rst;
        logic [31:0] p_rpc;
        int          lat;

        rsp_now = 1'b0;
        if (stale_inject) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
            stale_inject   = 1'b0;
        end else if (pend && wait_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(pend_addr);
            rsp_now        = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end

        if (rst === 1'b1 && imem_req_valid === 1'b1)
            check_eq("single_outstanding", {31'b0, pend}, 32'd0);

        hs      = (rst === 1'b1) && (imem_req_valid === 1'b1) && imem_req_ready;
        hs_addr = imem_addr;
        p_ins   = if_id_instruction;
        p_pc    = if_id_pc_out;
        p_valid = if_id_ins_valid;
        p_stall = stall;
        p_redir = redirect_valid;
        p_rst   = rst;
        p_rpc   = redirect_pc;

        @(posedge clk);
        #1;

        if (!p_rst) begin
            pend = 1'b0;
        end else begin
            if (rsp_now) pend = 1'b0;
            else if (pend) wait_cnt--;
            if (hs) begin
                lat       = (cfg_lat == 0) ? int'($urandom_range(1, 3)) : cfg_lat;
                pend      = 1'b1;
                pend_addr = hs_addr;
                wait_cnt  = lat - 1;
                hs_count++;
            end
        end

        if (!p_rst) begin
            check_eq("rst_valid", {31'b0, if_id_ins_valid}, 32'd0);
            check_eq("rst_insn", if_id_instruction, BUBBLE_INSN);
            check_eq("rst_pc", if_id_pc_out, 32'h0);
            check_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            exp_next   = RESET_PC;
            perf_model = 32'h0;
        end else if (p_redir) begin
            check_eq("flush_valid", {31'b0, if_id_ins_valid}, 32'd0);
            check_eq("flush_insn", if_id_instruction, BUBBLE_INSN);
            check_eq("flush_pc", if_id_pc_out, p_pc);
            exp_next = p_rpc;
        end else if (p_stall) begin
            check_eq("hold_valid", {31'b0, if_id_ins_valid}, {31'b0, p_valid});
            check_eq("hold_insn", if_id_instruction, p_ins);
            check_eq("hold_pc", if_id_pc_out, p_pc);
        end else if (if_id_ins_valid === 1'b1) begin
            check_eq("deliver_pc", if_id_pc_out, exp_next);
            check_eq("deliver_insn", if_id_instruction, memf(exp_next));
            exp_next = exp_next + 32'd4;
            deliveries++;
            perf_model = perf_model + 32'd1;
        end else begin
            check_eq("idle_insn", if_id_instruction, BUBBLE_INSN);
            check_eq("idle_pc", if_id_pc_out, p_pc);
        end
`ifdef IF_FETCH_PERF_EN
        check_eq("perf_count", if_fetch_count, perf_model);
`endif
    endtask

    int hs_before;

    initial begin
        rst            = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        cfg_lat        = 1;

        // Reset and first two sequential fetches
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        check_eq("t1_reqv", {31'b0, imem_req_valid}, 32'd1);
        check_eq("t1_addr0", imem_addr, 32'h0);
        cycle();
        check_eq("t1_not_yet", {31'b0, if_id_ins_valid}, 32'd0);
        cycle();
        check_eq("t1_i0_valid", {31'b0, if_id_ins_valid}, 32'd1);
        check_eq("t1_i0_insn", if_id_instruction, 32'h0050_0093);
        check_eq("t1_i0_pc", if_id_pc_out, 32'h0);
        check_eq("t1_addr4", imem_addr, 32'h4);
        cycle();
        cycle();
        check_eq("t1_i1_insn", if_id_instruction, 32'h0010_0113);
        check_eq("t1_i1_pc", if_id_pc_out, 32'h4);
        check_eq("t1_i1_valid", {31'b0, if_id_ins_valid}, 32'd1);

        // Stall across a response: skid buffer, no request in HOLD
        stall = 1'b1;
        cycle();
        check_eq("t2_hold_pc", if_id_pc_out, 32'h4);
        cycle();
        check_eq("t2_hold_noreq", {31'b0, imem_req_valid}, 32'd0);
        check_eq("t2_hold_valid", {31'b0, if_id_ins_valid}, 32'd1);
        cycle();
        check_eq("t2_hold_noreq2", {31'b0, imem_req_valid}, 32'd0);
        stall = 1'b0;
        cycle();
        check_eq("t2_buf_valid", {31'b0, if_id_ins_valid}, 32'd1);
        check_eq("t2_buf_pc", if_id_pc_out, 32'h8);
        check_eq("t2_buf_insn", if_id_instruction, memf(32'h8));
        check_eq("t2_next_addr", imem_addr, 32'hC);

        // Redirect during WAIT: late response dropped
        cfg_lat = 2;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cycle();
        check_eq("t3_flush_valid", {31'b0, if_id_ins_valid}, 32'd0);
        check_eq("t3_flush_insn", if_id_instruction, BUBBLE_INSN);
        redirect_valid = 1'b0;
        cycle();
        check_eq("t3_drop_valid", {31'b0, if_id_ins_valid}, 32'd0);
        check_eq("t3_req_addr", imem_addr, 32'h100);
        check_eq("t3_reqv", {31'b0, imem_req_valid}, 32'd1);
        cfg_lat = 1;
        cycle();
        cycle();
        check_eq("t3_new_pc", if_id_pc_out, 32'h100);
        check_eq("t3_new_valid", {31'b0, if_id_ins_valid}, 32'd1);

        // Memory not ready for 4 cycles
        imem_req_ready = 1'b0;
        hs_before      = hs_count;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check_eq("t4_reqv", {31'b0, imem_req_valid}, 32'd1);
            check_eq("t4_addr", imem_addr, 32'h104);
            check_eq("t4_novalid", {31'b0, if_id_ins_valid}, 32'd0);
        end
        imem_req_ready = 1'b1;
        cycle();
        cycle();
        check_eq("t4_one_hs", 32'(hs_count - hs_before), 32'd1);
        check_eq("t4_pc", if_id_pc_out, 32'h104);

        // Redirect together with stall while in HOLD
        cycle();
        stall = 1'b1;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cycle();
        check_eq("t5_flush_valid", {31'b0, if_id_ins_valid}, 32'd0);
        check_eq("t5_flush_insn", if_id_instruction, BUBBLE_INSN);
        check_eq("t5_addr", imem_addr, 32'h200);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        cycle();
        cycle();
        check_eq("t5_pc", if_id_pc_out, 32'h200);
        check_eq("t5_insn", if_id_instruction, memf(32'h200));

        // Reset while waiting; stale response afterwards is ignored
        cfg_lat = 3;
        cycle();
        rst = 1'b0;
        cycle();
`ifdef IF_FETCH_PERF_EN
        check_eq("t6_perf_zero", if_fetch_count, 32'h0);
`endif
        rst          = 1'b1;
        stale_inject = 1'b1;
        cycle();
        check_eq("t6_reqv", {31'b0, imem_req_valid}, 32'd1);
        check_eq("t6_addr", imem_addr, RESET_PC);
        check_eq("t6_no_stale", {31'b0, if_id_ins_valid}, 32'd0);
        cfg_lat = 1;
        cycle();
        cycle();
        check_eq("t6_first_pc", if_id_pc_out, RESET_PC);
        check_eq("t6_first_insn", if_id_instruction, 32'h0050_0093);

        // Randomized traffic
        cfg_lat = 0;
        deliveries = 0;
        for (int i = 0; i < 3000; i++) begin
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 7) == 0) redirect_pc = redirect_pc | 32'h2;
            imem_req_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        check_eq("random_progress", {31'b0, (deliveries > 100)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the pipelined core. It owns the PC, issues one outstanding request at a time to instruction memory over a valid/ready request and valid response interface, and loads the IF/ID pipeline register. It produces if_id_instruction, if_id_pc_out and if_id_ins_valid, which the ID/EX register consumes. It accepts a stall from the hazard unit and a PC redirect (branch/jump taken) from EX.

Parameters:
RESET_PC  32'h0000_0000  PC fetched first after reset
BUBBLE_INSN  32'h0000_0013  instruction word driven when IF/ID holds no valid instruction (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
stall  in  1  hold IF/ID register contents; no new instruction is delivered
redirect_valid  in  1  redirect fetch to redirect_pc this cycle
redirect_pc  in  32  new fetch PC
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  fetch address
imem_rsp_valid  in  1  response valid; exactly one per accepted request, at least 1 cycle later
imem_rsp_data  in  32  instruction word
if_id_instruction  out  32  IF/ID instruction
if_id_pc_out  out  32  PC of if_id_instruction
if_id_ins_valid  out  1  IF/ID holds a valid instruction

Behaviour:
- Reset: rst==0 at posedge clk. State goes to IDLE; pc=RESET_PC; kill=0; skid buffer empty; if_id_instruction=BUBBLE_INSN; if_id_pc_out=0; if_id_ins_valid=0; imem_req_valid=0. Reset overrides everything, including a response or request in flight. A response arriving after reset is released with no request outstanding is ignored.
- States: IDLE, REQ, WAIT, HOLD. Only one request is outstanding at a time.
- IDLE: go to REQ on the next cycle.
- REQ: imem_req_valid=1, imem_addr=pc.
  - Handshake (valid&&ready): fetch_pc<=pc, pc<=pc+4 (mod 2^32), go to WAIT.
  - redirect_valid with no handshake: pc<=redirect_pc, stay in REQ. The address may change while valid is held.
  - redirect_valid with handshake: pc<=redirect_pc, kill<=1, go to WAIT.
- WAIT: imem_req_valid=0.
  - rsp_valid and (kill or redirect_valid): drop the response, kill<=0, go to REQ. On redirect, pc<=redirect_pc.
  - rsp_valid, no stall: IF/ID<={rsp_data, fetch_pc, 1}, go to REQ.
  - rsp_valid with stall: capture {rsp_data, fetch_pc} in the skid buffer, go to HOLD.
  - redirect_valid without rsp_valid: kill<=1, pc<=redirect_pc.
- HOLD: imem_req_valid=0.
  - redirect_valid: discard the buffer, pc<=redirect_pc, go to REQ.
  - No stall: IF/ID<={buffer, 1}, go to REQ.
- IF/ID register priority each cycle:
  1. reset;
  2. redirect_valid (flush: valid=0, instruction=BUBBLE_INSN, pc_out held);
  3. stall (hold all three outputs);
  4. new delivery;
  5. otherwise valid=0 and instruction=BUBBLE_INSN.
- Redirect beats stall.
- Latency: with a 1-cycle memory response, the instruction appears in IF/ID 2 cycles after the request handshake. Throughput is 1 instruction per 2 cycles.
- All outputs are registered except imem_req_valid and imem_addr, which decode directly from state and pc.
- Misaligned redirect_pc is fetched as-is; alignment checking belongs to EX.

Optional Feature:
IF_FETCH_PERF_EN
- Defined: adds output if_fetch_count [31:0]. It resets to 0, increments by 1 on each cycle IF/ID loads a valid instruction (not on stall-hold), and wraps at 2^32.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset release, memory ready=1, rsp one cycle after each request, words 0x00500093, 0x00100113 -> imem_addr 0x0, then 0x4; IF/ID shows (0x00500093, pc 0x0, valid 1), then (0x00100113, pc 0x4, valid 1).
- stall=1 for 3 cycles while a response arrives in WAIT -> IF/ID holds its prior values; HOLD is entered; the buffered word is delivered on the first cycle after stall drops; no request is issued during HOLD.
- redirect_valid=1, redirect_pc=0x100 during WAIT -> IF/ID flushes to valid=0 / 0x00000013; the late response is dropped; the next request address is 0x100 and the next valid pc_out is 0x100.
- imem_req_ready=0 for 4 cycles -> imem_req_valid stays 1 with a stable addr; no IF/ID valid; exactly one handshake when ready rises.
- Redirect and stall asserted together in HOLD -> the buffer is discarded, IF/ID valid=0, next fetch is at redirect_pc.
- rst=0 asserted in WAIT, then released -> outputs return to reset values, the first request after release is at RESET_PC, and a stale response is not delivered; with IF_FETCH_PERF_EN, the count is 0.
